cone_cmp_sched: RTL

- Round-robin scheduler that time-shares one SLICE-bit magnitude-compare stage among NREQ requesters.
- The compare stage is the AOI/OAI greater/equal chain used in the jpeg timing cones.
- Each accepted request compares two WIDTH-bit unsigned operands MSB-first, one slice per cycle, and terminates early on the first unequal slice.
- Sits between the operand producers and the cone datapath. Replaces NREQ parallel full-width comparators.

---
 rtl/cone_cmp_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cone_cmp_sched.sv
// Round-robin scheduler sharing one SLICE-bit magnitude-compare stage among NREQ
// requesters; operands are compared MSB-first, one slice per cycle, with early exit.
module cone_cmp_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_gt,
  output logic                      rsp_eq,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int NSL = WIDTH / SLICE;
  localparam int SIW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int unsigned NR = NREQ;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("cone_cmp_sched: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [SIW-1:0]   slice_idx_q, slice_idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_gt_q, rsp_gt_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic             busy_q, busy_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SLICE-1:0] s_a, s_b;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NR) idx = idx - NR;
      if (!grant_vld && req_valid[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign req_ready = (state_q == IDLE && grant_vld && !rst) ? (NREQ'(1) << grant_id) : '0;

  // Shift the current slice up to the MSB end so one fixed part-select serves all slices.
  assign a_sh = a_q << (slice_idx_q * SLICE);
  assign b_sh = b_q << (slice_idx_q * SLICE);
  assign s_a  = a_sh[WIDTH-1 -: SLICE];
  assign s_b  = b_sh[WIDTH-1 -: SLICE];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    slice_idx_d = slice_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_gt_d    = rsp_gt_q;
    rsp_eq_d    = rsp_eq_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d         = req_a[grant_id*WIDTH +: WIDTH];
          b_d         = req_b[grant_id*WIDTH +: WIDTH];
          id_d        = grant_id;
          slice_idx_d = '0;
          rr_ptr_d    = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
          state_d     = CMP;
        end
      end
      CMP: begin
        if (s_a != s_b) begin
          rsp_gt_d    = (s_a > s_b);
          rsp_eq_d    = 1'b0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (slice_idx_q == SIW'(NSL-1)) begin
          rsp_gt_d    = 1'b0;
          rsp_eq_d    = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          slice_idx_d = slice_idx_q + SIW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      slice_idx_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      slice_idx_q <= slice_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gt_q    <= rsp_gt_d;
      rsp_eq_q    <= rsp_eq_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_eq    = rsp_eq_q;
  assign busy      = busy_q;

endmodule
